// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a multi-cycle RV32I subset core sharing one memory port; lw 5, sw/ALU/jal 4, branch 3 cycles.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; a programmable wait limit traps to HALT with mem_err.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Wide enough to hold MEM_TIMEOUT itself, and at least one bit when the timeout is disabled.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_HALT
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.mem_req  = 1'b1;
        c.mem_read = 1'b1;
        c.adr_src  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_EXECR: c.alu_src_a = 2'b10;
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
      end
      S_BRANCH: c.alu_src_a = 2'b10;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t            state_q, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;

  logic [WAIT_W-1:0] wait_inc;
  logic              timeout_hit;
  logic              retire;
  logic              in_wait_state;

  always_comb begin
    wait_inc    = wait_q + WAIT_W'(1);
    // A same-cycle mem_ready always takes priority over the timeout.
    timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_inc == WAIT_W'(MEM_TIMEOUT));
    in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

    state_d   = state_q;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BR: begin
            if (funct3[2:1] == 2'b00) begin
              state_d = S_BRANCH;
            end else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d   = S_HALT;
          mem_err_d = 1'b1;
        end
      end
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    // Restart the wait count on every state change so each access gets the full budget.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_wait_state && !mem_ready) begin
      wait_d = wait_inc;
    end else begin
      wait_d = wait_q;
    end

    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  logic       run;
  logic [2:0] funct_alu;
  logic [2:0] alu_sel;
  logic [1:0] imm_sel;
  logic       pc_write;
  logic       ir_write;

  always_comb begin
    run = !rst;

    case (funct3)
      3'b000:  funct_alu = (op[5] && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase

    case (state_q)
      S_EXECR, S_EXECI: alu_sel = funct_alu;
      S_BRANCH:         alu_sel = ALU_SUB;
      default:          alu_sel = ALU_ADD;
    endcase

    case (op)
      OP_SW:   imm_sel = 2'b01;
      OP_BR:   imm_sel = 2'b10;
      OP_JAL:  imm_sel = 2'b11;
      default: imm_sel = 2'b00;
    endcase

    ir_write = (state_q == S_FETCH) && mem_ready;
    pc_write = ir_write || (state_q == S_JAL) ||
               ((state_q == S_BRANCH) && (Zero ^ funct3[0]));

    mem_req    = run & ctrl_q.mem_req;
    MemRead    = run & ctrl_q.mem_read;
    MemWrite   = run & ctrl_q.mem_write;
    AdrSrc     = run & ctrl_q.adr_src;
    RegWrite   = run & ctrl_q.reg_write;
    IRWrite    = run & ir_write;
    PCWrite    = run & pc_write;
    ResultSrc  = run ? ctrl_q.result_src : 2'b00;
    ALUSrcA    = run ? ctrl_q.alu_src_a : 2'b00;
    ALUSrcB    = run ? ctrl_q.alu_src_b : 2'b00;
    ImmSrc     = run ? imm_sel : 2'b00;
    ALUControl = run ? alu_sel : 3'b000;
    illegal_op = run & illegal_q;
    mem_err    = run & mem_err_q;
    retired    = run ? retired_q : '0;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit (MEM_TIMEOUT=4, CNT_W=2).
// Each row drives one cycle of inputs and checks the full control word plus the retired count.
module tb_multicycle_control_unit;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_op, mem_err;
  logic [1:0] retired;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal_op(illegal_op), .mem_err(mem_err), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        rdy;
    logic [19:0] exp;
    logic [1:0]  ret;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Control word layout: mem_req MemRead MemWrite AdrSrc IRWrite PCWrite RegWrite
  // ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl illegal_op mem_err
  function automatic logic [19:0] cw(input logic mreq, mrd, mwr, adr, irw, pcw, rgw,
                                     input logic [1:0] rs, sa, sb, imm,
                                     input logic [2:0] alu, input logic ill, merr);
    return {mreq, mrd, mwr, adr, irw, pcw, rgw, rs, sa, sb, imm, alu, ill, merr};
  endfunction

  function automatic logic [19:0] e_fetch(input logic rdy, input logic [1:0] imm);
    return cw(1, 1, 0, 0, rdy, rdy, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_dec(input logic [1:0] imm);
    return cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_madr(input logic [1:0] imm);
    return cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_mrd(input logic [1:0] imm);
    return cw(1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_mwr(input logic [1:0] imm);
    return cw(1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_mwb(input logic [1:0] imm);
    return cw(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_exr(input logic [2:0] alu);
    return cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [19:0] e_exi(input logic [2:0] alu);
    return cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [19:0] e_awb(input logic [1:0] imm);
    return cw(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_jal();
    return cw(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_br(input logic pcw);
    return cw(0, 0, 0, 0, 0, pcw, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0, 0);
  endfunction
  function automatic logic [19:0] e_halt(input logic [1:0] imm, input logic ill, merr);
    return cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, ill, merr);
  endfunction

  function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f3,
                              input logic f7, z, rdy, input logic [19:0] e, input logic [1:0] rt);
    vec_t v;
    v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.rdy = rdy;
    v.exp = e; v.ret = rt;
    return v;
  endfunction

  // Four-row zero-wait R/I-type instruction: FETCH, DECODE, EXEC, ALUWB.
  task automatic push_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [19:0] ex, input logic [1:0] rt);
    tbl.push_back(mk(0, o, f3, f7, 0, 1, e_fetch(1, 2'b00), rt));
    tbl.push_back(mk(0, o, f3, f7, 0, 1, e_dec(2'b00), rt));
    tbl.push_back(mk(0, o, f3, f7, 0, 1, ex, rt));
    tbl.push_back(mk(0, o, f3, f7, 0, 1, e_awb(2'b00), rt));
  endtask

  task automatic run_row(input vec_t v, input int id);
    logic [19:0] act;
    rst = v.rst; op = v.op; funct3 = v.f3; funct7_5 = v.f7; Zero = v.zero; mem_ready = v.rdy;
    #2;
    act = {mem_req, MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, mem_err};
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL row %0d ctrl: got=%b want=%b", id, act, v.exp);
    end
    checks++;
    if (retired !== v.ret) begin
      errors++;
      $display("FAIL row %0d retired: got=%0d want=%0d", id, retired, v.ret);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;

    // Reset: everything forced low, even with mem_ready asserted.
    tbl.push_back(mk(1, OP_R, 3'b000, 0, 0, 0, 20'b0, 2'd0));
    tbl.push_back(mk(1, OP_R, 3'b000, 0, 0, 1, 20'b0, 2'd0));
    // add, zero-wait; mem_ready stays high through non-request states.
    push_alu(OP_R, 3'b000, 0, e_exr(3'b000), 2'd0);
    // lw with three wait cycles in MEMREAD.
    tbl.push_back(mk(0, OP_LW, 3'b010, 0, 0, 1, e_fetch(1, 2'b00), 2'd1));
    tbl.push_back(mk(0, OP_LW, 3'b010, 0, 0, 1, e_dec(2'b00), 2'd1));
    tbl.push_back(mk(0, OP_LW, 3'b010, 0, 0, 0, e_madr(2'b00), 2'd1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, OP_LW, 3'b010, 0, 0, 0, e_mrd(2'b00), 2'd1));
    tbl.push_back(mk(0, OP_LW, 3'b010, 0, 0, 1, e_mrd(2'b00), 2'd1));
    tbl.push_back(mk(0, OP_LW, 3'b010, 0, 0, 1, e_mwb(2'b00), 2'd1));
    // beq taken, then bne not taken, both with Zero=1.
    tbl.push_back(mk(0, OP_BR, 3'b000, 0, 1, 1, e_fetch(1, 2'b10), 2'd2));
    tbl.push_back(mk(0, OP_BR, 3'b000, 0, 1, 1, e_dec(2'b10), 2'd2));
    tbl.push_back(mk(0, OP_BR, 3'b000, 0, 1, 1, e_br(1), 2'd2));
    tbl.push_back(mk(0, OP_BR, 3'b001, 0, 1, 1, e_fetch(1, 2'b10), 2'd3));
    tbl.push_back(mk(0, OP_BR, 3'b001, 0, 1, 1, e_dec(2'b10), 2'd3));
    tbl.push_back(mk(0, OP_BR, 3'b001, 0, 1, 1, e_br(0), 2'd3));
    // sw zero-wait; counter has wrapped to 0 here.
    tbl.push_back(mk(0, OP_SW, 3'b010, 0, 0, 1, e_fetch(1, 2'b01), 2'd0));
    tbl.push_back(mk(0, OP_SW, 3'b010, 0, 0, 1, e_dec(2'b01), 2'd0));
    tbl.push_back(mk(0, OP_SW, 3'b010, 0, 0, 1, e_madr(2'b01), 2'd0));
    tbl.push_back(mk(0, OP_SW, 3'b010, 0, 0, 1, e_mwr(2'b01), 2'd0));
    // Funct decode variety.
    push_alu(OP_R, 3'b000, 1, e_exr(3'b001), 2'd1);
    push_alu(OP_I, 3'b110, 1, e_exi(3'b011), 2'd2);
    push_alu(OP_I, 3'b000, 1, e_exi(3'b000), 2'd3);
    push_alu(OP_R, 3'b010, 0, e_exr(3'b101), 2'd0);
    push_alu(OP_R, 3'b111, 0, e_exr(3'b010), 2'd1);
    // jal
    tbl.push_back(mk(0, OP_JAL, 3'b000, 0, 0, 1, e_fetch(1, 2'b11), 2'd2));
    tbl.push_back(mk(0, OP_JAL, 3'b000, 0, 0, 1, e_dec(2'b11), 2'd2));
    tbl.push_back(mk(0, OP_JAL, 3'b000, 0, 0, 1, e_jal(), 2'd2));
    tbl.push_back(mk(0, OP_JAL, 3'b000, 0, 0, 1, e_awb(2'b11), 2'd2));
    // Illegal opcode, HALT absorbs, reset clears.
    tbl.push_back(mk(0, OP_BAD, 3'b000, 0, 0, 1, e_fetch(1, 2'b00), 2'd3));
    tbl.push_back(mk(0, OP_BAD, 3'b000, 0, 0, 1, e_dec(2'b00), 2'd3));
    tbl.push_back(mk(0, OP_BAD, 3'b000, 0, 0, 1, e_halt(2'b00, 1, 0), 2'd3));
    tbl.push_back(mk(0, OP_BAD, 3'b000, 0, 0, 1, e_halt(2'b00, 1, 0), 2'd3));
    tbl.push_back(mk(1, OP_BAD, 3'b000, 0, 0, 1, 20'b0, 2'd0));
    // Fetch timeout: four waiting FETCH cycles, then HALT with mem_err.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, OP_R, 3'b000, 0, 0, 0, e_fetch(0, 2'b00), 2'd0));
    tbl.push_back(mk(0, OP_R, 3'b000, 0, 0, 0, e_halt(2'b00, 0, 1), 2'd0));
    tbl.push_back(mk(0, OP_R, 3'b000, 0, 0, 1, e_halt(2'b00, 0, 1), 2'd0));
    tbl.push_back(mk(1, OP_R, 3'b000, 0, 0, 0, 20'b0, 2'd0));
    // Branch with unsupported funct3 traps in DECODE.
    tbl.push_back(mk(0, OP_BR, 3'b010, 0, 0, 1, e_fetch(1, 2'b10), 2'd0));
    tbl.push_back(mk(0, OP_BR, 3'b010, 0, 0, 1, e_dec(2'b10), 2'd0));
    tbl.push_back(mk(0, OP_BR, 3'b010, 0, 0, 1, e_halt(2'b10, 1, 0), 2'd0));
    tbl.push_back(mk(1, OP_BR, 3'b010, 0, 0, 0, 20'b0, 2'd0));

    foreach (tbl[i]) run_row(tbl[i], i);

    // mem_ready arriving in the very cycle the timeout would fire must win.
    for (int i = 0; i < 3; i++) run_row(mk(0, OP_R, 3'b000, 0, 0, 0, e_fetch(0, 2'b00), 2'd0), 100 + i);
    run_row(mk(0, OP_R, 3'b000, 0, 0, 1, e_fetch(1, 2'b00), 2'd0), 103);
    run_row(mk(0, OP_R, 3'b000, 0, 0, 0, e_dec(2'b00), 2'd0), 104);
    run_row(mk(0, OP_R, 3'b000, 0, 0, 0, e_exr(3'b000), 2'd0), 105);
    run_row(mk(0, OP_R, 3'b000, 0, 0, 0, e_awb(2'b00), 2'd0), 106);

    // Reset in the middle of a load: no strobe, no retirement, FETCH restarts.
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 1, e_fetch(1, 2'b00), 2'd1), 200);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_dec(2'b00), 2'd1), 201);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_madr(2'b00), 2'd1), 202);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_mrd(2'b00), 2'd1), 203);
    run_row(mk(1, OP_LW, 3'b010, 0, 0, 1, 20'b0, 2'd0), 204);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_fetch(0, 2'b00), 2'd0), 205);

    // Wait count restarts on entering MEMREAD: two FETCH waits do not shorten its budget.
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_fetch(0, 2'b00), 2'd0), 300);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 1, e_fetch(1, 2'b00), 2'd0), 301);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_dec(2'b00), 2'd0), 302);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_madr(2'b00), 2'd0), 303);
    for (int i = 0; i < 4; i++) run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_mrd(2'b00), 2'd0), 304 + i);
    run_row(mk(0, OP_LW, 3'b010, 0, 0, 0, e_halt(2'b00, 0, 1), 2'd0), 308);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
